// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode/execute controls and the IF/ID outputs.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    // Environment side: memory and pipeline control
    modport master (
        output imem_rdata, stall, redirect, redirect_pc,
        input  imem_addr, if_valid, if_pc, if_instr, if_fault
    );

    // Fetch unit side
    modport slave (
        input  imem_rdata, stall, redirect, redirect_pc,
        output imem_addr, if_valid, if_pc, if_instr, if_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: PC ownership, 1-cycle synchronous imem read,
// IF/ID output with stall hold, redirect flush and alignment/range faults.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    fetch_unit_if.slave io_fetch
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    // Highest byte address whose full word still lies inside the memory
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {StRun, StHold, StFault} state_e;

    state_e      r_state,      w_state_nxt;
    logic [31:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic [31:0] r_resp_pc,    w_resp_pc_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic [31:0] r_hold_instr, w_hold_instr_nxt;
    logic        r_hold_valid, w_hold_valid_nxt;

    logic w_fault;
    logic w_resp_fault;

    assign w_fault      = (r_resp_pc[1:0] != 2'b00) || (r_resp_pc > LAST_PC);
    assign w_resp_fault = r_resp_valid && w_fault;

    // State register; synchronous reset has top priority
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StRun;
            r_fetch_pc   <= RESET_PC;
            r_resp_pc    <= '0;
            r_resp_valid <= 1'b0;
            r_hold_instr <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_resp_pc    <= w_resp_pc_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_valid <= w_hold_valid_nxt;
        end
    end

    // Next-state: redirect > fault freeze > stall hold > advance
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_resp_pc_nxt    = r_resp_pc;
        w_resp_valid_nxt = r_resp_valid;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_valid_nxt = r_hold_valid;

        if (io_fetch.redirect) begin
            // Drop whatever is in flight; the next edge yields one bubble
            w_state_nxt      = StRun;
            w_fetch_pc_nxt   = io_fetch.redirect_pc;
            w_resp_valid_nxt = 1'b0;
            w_hold_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_resp_fault) begin
                        w_state_nxt = StFault;
                    end else if (io_fetch.stall && r_resp_valid) begin
                        // Capture the word now on imem_rdata; fetch_pc is left alone so
                        // the memory keeps returning the following word for release.
                        w_state_nxt      = StHold;
                        w_hold_instr_nxt = io_fetch.imem_rdata;
                        w_hold_valid_nxt = 1'b1;
                    end else begin
                        w_resp_pc_nxt    = r_fetch_pc;
                        w_resp_valid_nxt = 1'b1;
                        w_fetch_pc_nxt   = r_fetch_pc + 32'd4;
                    end
                end
                StHold: begin
                    if (!io_fetch.stall) begin
                        w_state_nxt      = StRun;
                        w_hold_valid_nxt = 1'b0;
                        w_resp_pc_nxt    = r_fetch_pc;
                        w_resp_valid_nxt = 1'b1;
                        w_fetch_pc_nxt   = r_fetch_pc + 32'd4;
                    end
                end
                StFault: begin
                    // Frozen until redirect or reset
                end
                default: begin
                    w_state_nxt = StRun;
                end
            endcase
        end
    end

    // IF/ID outputs; NOP whenever the slot is empty or faulting
    always_comb begin
        io_fetch.imem_addr = r_fetch_pc;
        io_fetch.if_valid  = r_resp_valid;
        io_fetch.if_pc     = r_resp_valid ? r_resp_pc : 32'h0;
        io_fetch.if_fault  = w_resp_fault;
        if (!r_resp_valid || w_fault) begin
            io_fetch.if_instr = NOP;
        end else if (r_hold_valid) begin
            io_fetch.if_instr = r_hold_instr;
        end else begin
            io_fetch.if_instr = io_fetch.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected IF/ID tuples go into a scoreboard queue
// as each cycle's stimulus is driven and are popped and compared after the edge.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       tag;
        logic        valid;
        logic        pc_chk;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] mem [64];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    fetch_unit_if u_if ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (256)
    ) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .io_fetch (u_if.slave)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous instruction memory
    always @(posedge clk) begin
        u_if.imem_rdata <= mem[u_if.imem_addr[7:2]];
    end

    function automatic logic [31:0] word(input int idx);
        return 32'h11 * (idx + 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t ex_ok(input string tag, input logic [31:0] pc);
        exp_t e;
        e.tag = tag; e.valid = 1'b1; e.pc_chk = 1'b1; e.pc = pc;
        e.instr = word(int'(pc[7:2])); e.fault = 1'b0;
        return e;
    endfunction

    function automatic exp_t ex_bub(input string tag);
        exp_t e;
        e.tag = tag; e.valid = 1'b0; e.pc_chk = 1'b0; e.pc = '0;
        e.instr = NOP; e.fault = 1'b0;
        return e;
    endfunction

    function automatic exp_t ex_rst(input string tag);
        exp_t e;
        e = ex_bub(tag);
        e.pc_chk = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_flt(input string tag, input logic [31:0] pc);
        exp_t e;
        e.tag = tag; e.valid = 1'b1; e.pc_chk = 1'b1; e.pc = pc;
        e.instr = NOP; e.fault = 1'b1;
        return e;
    endfunction

    // Drive one cycle of inputs, record the expected post-edge outputs, then compare
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input exp_t e);
        exp_t got;
        rst              = r;
        u_if.stall       = s;
        u_if.redirect    = rd;
        u_if.redirect_pc = rpc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq({got.tag, ".valid"}, {31'b0, u_if.if_valid}, {31'b0, got.valid});
        check_eq({got.tag, ".instr"}, u_if.if_instr, got.instr);
        check_eq({got.tag, ".fault"}, {31'b0, u_if.if_fault}, {31'b0, got.fault});
        if (got.pc_chk) begin
            check_eq({got.tag, ".pc"}, u_if.if_pc, got.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = word(i);
        end
        u_if.stall       = 1'b0;
        u_if.redirect    = 1'b0;
        u_if.redirect_pc = '0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, ex_rst("rst"));
        end
        check_eq("rst.imem_addr", u_if.imem_addr, 32'h0);

        // Straight-line start
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("run0", 32'h0));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("run1", 32'h4));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("run2", 32'h8));

        // Stall three cycles at pc 8, then no skip or repeat
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0, ex_ok("stall", 32'h8));
        end
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("unstall0", 32'hC));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("unstall1", 32'h10));

        // Redirect from 0x10 to 0x40
        cyc(1'b0, 1'b0, 1'b1, 32'h40, ex_bub("redir.bub"));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("redir0", 32'h40));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("redir1", 32'h44));

        // Redirect with stall on the same edge; stall during the bubble is ignored
        cyc(1'b0, 1'b1, 1'b1, 32'h10, ex_bub("rdst.bub"));
        cyc(1'b0, 1'b1, 1'b0, '0, ex_ok("rdst0", 32'h10));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("rdst1", 32'h14));

        // Misaligned redirect target faults after the bubble and freezes
        cyc(1'b0, 1'b0, 1'b1, 32'h42, ex_bub("mis.bub"));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_flt("mis.flt", 32'h42));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'(i % 2), 1'b0, '0, ex_flt("mis.frz", 32'h42));
        end
        check_eq("mis.imem_addr", u_if.imem_addr, 32'h46);
        cyc(1'b0, 1'b0, 1'b1, 32'h0, ex_bub("rec.bub"));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("rec0", 32'h0));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("rec1", 32'h4));

        // Run off the end of the memory
        cyc(1'b0, 1'b0, 1'b1, 32'hF8, ex_bub("rng.bub"));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("rng.f8", 32'hF8));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("rng.fc", 32'hFC));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_flt("rng.flt", 32'h100));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, '0, ex_flt("rng.frz", 32'h100));
        end

        // Reset out of FAULT
        cyc(1'b1, 1'b0, 1'b0, '0, ex_rst("frst"));
        check_eq("frst.imem_addr", u_if.imem_addr, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("frst0", 32'h0));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("frst1", 32'h4));

        // Reset in the middle of a stall
        cyc(1'b0, 1'b1, 1'b0, '0, ex_ok("srst.hold", 32'h4));
        cyc(1'b1, 1'b1, 1'b0, '0, ex_rst("srst"));
        cyc(1'b0, 1'b0, 1'b0, '0, ex_ok("srst0", 32'h0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
